instr_sequencer: RTL and testbench

- Upstream feeder for the 4-bit processor top level.
- Captures a short program of 8-bit instructions entered from board switches into a small buffer. On command, replays them in order into the processor's instruction/execute inputs.
- Each instruction is issued only after the processor's Done handshake for the previous one.
- Lets a whole program run from one button instead of hand-toggling execute per instruction.

---
 rtl/instr_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: captures a short program of 8-bit instructions from
// board switches and replays it, one instruction per Done handshake, into
// the 4-bit processor's instruction/execute inputs.
//
// Optional build feature (macro INSTR_SEQUENCER_LOOP_EN):
//   defined   - replay loops forever; a second run pulse while busy stops
//               the loop once the current instruction completes.
//   undefined - single pass per run; run pulses while busy are ignored.
module instr_sequencer #(
    parameter int DEPTH   = 8,   // instruction slots, power of 2, 2..16
    parameter int TIMEOUT = 15   // max cycles waiting for Done, 1..255
) (
    input  logic       clk,
    input  logic       reset,        // asynchronous, active-low
    input  logic       load,
    input  logic [7:0] sw_instr,
    input  logic       run,
    input  logic       clear,
    input  logic       Done,
    output logic [7:0] instruction,
    output logic       execute,
    output logic [3:0] count,
    output logic       busy,
    output logic       overflow,
    output logic       timeout_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_DONE = 3'd2;
    localparam logic [2:0] S_WAIT_LOW  = 3'd3;
    localparam logic [2:0] S_ERROR     = 3'd4;

    localparam logic [4:0]    DEPTH_C  = 5'(DEPTH);
    localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // The stored count is 5 bits so DEPTH=16 can be represented; the
    // 4-bit port saturates at 15.
    function automatic logic [3:0] sat_count(input logic [4:0] c);
        if (c > 5'd15) begin
            sat_count = 4'd15;
        end else begin
            sat_count = c[3:0];
        end
    endfunction

    logic [7:0]    r_mem [DEPTH];
    logic [2:0]    r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [4:0]    r_count;
    logic [7:0]    r_tcnt;
    logic [7:0]    r_instr;
    logic          r_execute;
    logic [3:0]    r_count_o;
    logic          r_busy;
    logic          r_overflow;
    logic          r_timeout_err;
    logic          r_stop_req;

    logic [2:0]    w_state;
    logic [AW-1:0] w_wr_ptr;
    logic [AW-1:0] w_rd_ptr;
    logic [4:0]    w_count;
    logic [7:0]    w_tcnt;
    logic [7:0]    w_instr;
    logic          w_execute;
    logic          w_busy;
    logic          w_overflow;
    logic          w_timeout_err;
    logic          w_stop_req;
    logic          w_mem_we;
    logic          w_last;

    assign w_last = (5'(r_rd_ptr) == (r_count - 5'd1));

    // Next-state logic: clear beats run, run beats load.  Execute is raised
    // together with the instruction word on every transition into ISSUE so
    // both are registered and valid for the whole ISSUE cycle.
    always_comb begin
        w_state       = r_state;
        w_wr_ptr      = r_wr_ptr;
        w_rd_ptr      = r_rd_ptr;
        w_count       = r_count;
        w_tcnt        = r_tcnt;
        w_instr       = r_instr;
        w_execute     = 1'b0;
        w_busy        = r_busy;
        w_overflow    = r_overflow;
        w_timeout_err = r_timeout_err;
        w_stop_req    = r_stop_req;
        w_mem_we      = 1'b0;

`ifdef INSTR_SEQUENCER_LOOP_EN
        if (run && r_busy) begin
            w_stop_req = 1'b1;
        end else begin
            w_stop_req = r_stop_req;
        end
`endif

        if (clear) begin
            w_state       = S_IDLE;
            w_wr_ptr      = PTR_ZERO;
            w_rd_ptr      = PTR_ZERO;
            w_count       = 5'd0;
            w_busy        = 1'b0;
            w_overflow    = 1'b0;
            w_timeout_err = 1'b0;
            w_stop_req    = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        if (r_count != 5'd0) begin
                            w_state       = S_ISSUE;
                            w_rd_ptr      = PTR_ZERO;
                            w_instr       = r_mem[PTR_ZERO];
                            w_execute     = 1'b1;
                            w_busy        = 1'b1;
                            w_timeout_err = 1'b0;
                            w_stop_req    = 1'b0;
                        end else begin
                            w_state = S_IDLE;
                        end
                    end else if (load) begin
                        if (r_count < DEPTH_C) begin
                            w_mem_we = 1'b1;
                            w_wr_ptr = r_wr_ptr + PTR_ONE;
                            w_count  = r_count + 5'd1;
                        end else begin
                            w_overflow = 1'b1;
                        end
                    end else begin
                        w_state = S_IDLE;
                    end
                end
                S_ISSUE: begin
                    w_tcnt  = 8'd0;
                    w_state = S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (Done) begin
                        w_state = S_WAIT_LOW;
                    end else if (r_tcnt == TMO_LAST) begin
                        w_state       = S_ERROR;
                        w_timeout_err = 1'b1;
                        w_busy        = 1'b0;
                        w_stop_req    = 1'b0;
                    end else begin
                        w_tcnt = r_tcnt + 8'd1;
                    end
                end
                S_WAIT_LOW: begin
                    if (!Done) begin
                        if (w_stop_req) begin
                            w_state    = S_IDLE;
                            w_busy     = 1'b0;
                            w_stop_req = 1'b0;
                        end else if (w_last) begin
`ifdef INSTR_SEQUENCER_LOOP_EN
                            w_state   = S_ISSUE;
                            w_rd_ptr  = PTR_ZERO;
                            w_instr   = r_mem[PTR_ZERO];
                            w_execute = 1'b1;
`else
                            w_state = S_IDLE;
                            w_busy  = 1'b0;
`endif
                        end else begin
                            w_state   = S_ISSUE;
                            w_rd_ptr  = r_rd_ptr + PTR_ONE;
                            w_instr   = r_mem[r_rd_ptr + PTR_ONE];
                            w_execute = 1'b1;
                        end
                    end else begin
                        w_state = S_WAIT_LOW;
                    end
                end
                S_ERROR: begin
                    // A run restarts straight away when there is a program;
                    // otherwise it just returns to IDLE.
                    if (run) begin
                        if (r_count != 5'd0) begin
                            w_state       = S_ISSUE;
                            w_rd_ptr      = PTR_ZERO;
                            w_instr       = r_mem[PTR_ZERO];
                            w_execute     = 1'b1;
                            w_busy        = 1'b1;
                            w_timeout_err = 1'b0;
                            w_stop_req    = 1'b0;
                        end else begin
                            w_state = S_IDLE;
                        end
                    end else begin
                        w_state = S_ERROR;
                    end
                end
                default: begin
                    w_state    = S_IDLE;
                    w_busy     = 1'b0;
                    w_stop_req = 1'b0;
                end
            endcase
        end
    end

    // Program buffer: contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= sw_instr;
        end
    end

    // Control and output registers; reset aborts any run immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= PTR_ZERO;
            r_rd_ptr      <= PTR_ZERO;
            r_count       <= 5'd0;
            r_tcnt        <= 8'd0;
            r_instr       <= 8'h00;
            r_execute     <= 1'b0;
            r_count_o     <= 4'd0;
            r_busy        <= 1'b0;
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_stop_req    <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_wr_ptr      <= w_wr_ptr;
            r_rd_ptr      <= w_rd_ptr;
            r_count       <= w_count;
            r_tcnt        <= w_tcnt;
            r_instr       <= w_instr;
            r_execute     <= w_execute;
            r_count_o     <= sat_count(w_count);
            r_busy        <= w_busy;
            r_overflow    <= w_overflow;
            r_timeout_err <= w_timeout_err;
            r_stop_req    <= w_stop_req;
        end
    end

    assign instruction = r_instr;
    assign execute     = r_execute;
    assign count       = r_count_o;
    assign busy        = r_busy;
    assign overflow    = r_overflow;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer (DEPTH=8, TIMEOUT=15): expected
// instruction words are queued as a replay is started and popped as each
// execute strobe appears.
module tb_instr_sequencer;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] sw_instr;
    logic       run;
    logic       clear;
    logic       Done;
    logic [7:0] instruction;
    logic       execute;
    logic [3:0] count;
    logic       busy;
    logic       overflow;
    logic       timeout_err;

    int         n_tests;
    int         n_fail;
    int         n_exec;
    logic       done_en;
    logic       prev_exec;
    logic [7:0] exp_q[$];

    instr_sequencer #(.DEPTH(8), .TIMEOUT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .sw_instr    (sw_instr),
        .run         (run),
        .clear       (clear),
        .Done        (Done),
        .instruction (instruction),
        .execute     (execute),
        .count       (count),
        .busy        (busy),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] w);
        @(posedge clk); #1;
        load = 1'b1; sw_instr = w;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic pulse_run;
        @(posedge clk); #1;
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
    endtask

    task automatic pulse_clear;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk_val("idle_bound", {31'd0, busy}, 32'd0);
    endtask

    // Scoreboard monitor: every execute must be a single-cycle pulse and
    // carry the next expected word.
    always @(negedge clk) begin
        if (execute) begin
            n_exec <= n_exec + 1;
            chk_val("exec_width", {31'd0, prev_exec}, 32'd0);
            if (exp_q.size() == 0) begin
                chk_val("exec_unexp", 32'd1, 32'd0);
            end else begin
                chk_val("instr", {24'd0, instruction}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_exec <= execute;
    end

    // Processor model: Done rises 3 cycles after an execute, holds 2 cycles.
    initial begin
        Done = 1'b0;
        forever begin
            @(negedge clk);
            if (execute && done_en) begin
                repeat (3) @(posedge clk);
                #1 Done = 1'b1;
                repeat (2) @(posedge clk);
                #1 Done = 1'b0;
            end
        end
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; n_exec = 0; prev_exec = 1'b0;
        reset = 1'b0; load = 1'b0; sw_instr = 8'h00; run = 1'b0;
        clear = 1'b0; done_en = 1'b0;
        repeat (2) @(posedge clk); #1;

        // reset state
        chk_val("rst_instr", {24'd0, instruction}, 32'h00);
        chk_val("rst_exec",  {31'd0, execute}, 32'd0);
        chk_val("rst_count", {28'd0, count}, 32'd0);
        chk_val("rst_busy",  {31'd0, busy}, 32'd0);
        chk_val("rst_ovf",   {31'd0, overflow}, 32'd0);
        chk_val("rst_tmo",   {31'd0, timeout_err}, 32'd0);
        reset = 1'b1;

        // three-word program, replayed twice
        do_load(8'h12); do_load(8'h34); do_load(8'h56);
        chk_val("load3_count", {28'd0, count}, 32'd3);
        done_en = 1'b1;
        exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h56);
        pulse_run;
        chk_val("run_lat", {31'd0, execute}, 32'd1);
        chk_val("run_busy", {31'd0, busy}, 32'd1);
        wait_idle(200);
        chk_val("p1_sb", exp_q.size(), 32'd0);
        chk_val("p1_count", {28'd0, count}, 32'd3);
        chk_val("p1_ovf", {31'd0, overflow}, 32'd0);
        exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h56);
        pulse_run;
        wait_idle(200);
        chk_val("p2_sb", exp_q.size(), 32'd0);

        // overflow: nine loads into eight slots
        pulse_clear;
        for (int i = 0; i < 9; i++) begin
            do_load(8'hA0 + 8'(i));
        end
        chk_val("ovf_count", {28'd0, count}, 32'd8);
        chk_val("ovf_flag", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'hA0 + 8'(i));
        end
        pulse_run;
        wait_idle(400);
        chk_val("ovf_sb", exp_q.size(), 32'd0);

        // timeout: Done never arrives
        pulse_clear;
        chk_val("clr_ovf", {31'd0, overflow}, 32'd0);
        do_load(8'h5C);
        done_en = 1'b0;
        exp_q.push_back(8'h5C);
        pulse_run;
        repeat (15) begin
            @(posedge clk); #1;
        end
        chk_val("tmo_early", {31'd0, timeout_err}, 32'd0);
        @(posedge clk); #1;
        chk_val("tmo_flag", {31'd0, timeout_err}, 32'd1);
        chk_val("tmo_busy", {31'd0, busy}, 32'd0);
        chk_val("tmo_instr", {24'd0, instruction}, 32'h5C);
        pulse_clear;
        chk_val("tmo_clr", {31'd0, timeout_err}, 32'd0);
        chk_val("tmo_clr_count", {28'd0, count}, 32'd0);

        // run with empty buffer, then clear+load together
        pulse_run;
        chk_val("empty_exec", {31'd0, execute}, 32'd0);
        repeat (4) begin
            @(posedge clk); #1;
            chk_val("empty_busy", {31'd0, busy}, 32'd0);
        end
        do_load(8'h77);
        @(posedge clk); #1;
        clear = 1'b1; load = 1'b1; sw_instr = 8'h88;
        @(posedge clk); #1;
        clear = 1'b0; load = 1'b0;
        chk_val("clr_load_count", {28'd0, count}, 32'd0);

        // asynchronous reset in WAIT_DONE
        do_load(8'hC3);
        exp_q.push_back(8'hC3);
        pulse_run;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk_val("mid_busy", {31'd0, busy}, 32'd1);
        #3 reset = 1'b0;
        #1;
        chk_val("arst_exec",  {31'd0, execute}, 32'd0);
        chk_val("arst_busy",  {31'd0, busy}, 32'd0);
        chk_val("arst_instr", {24'd0, instruction}, 32'h00);
        chk_val("arst_count", {28'd0, count}, 32'd0);
        #1 reset = 1'b1;

`ifdef INSTR_SEQUENCER_LOOP_EN
        // looped replay stopped by a second run pulse
        begin
            int n;
            int base;
            do_load(8'hE1); do_load(8'hE2);
            done_en = 1'b1;
            exp_q.push_back(8'hE1); exp_q.push_back(8'hE2); exp_q.push_back(8'hE1);
            base = n_exec;
            pulse_run;
            n = 0;
            while (n_exec < base + 3 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk_val("loop_seen3", n_exec - base, 32'd3);
            pulse_run;
            wait_idle(200);
            chk_val("loop_execs", n_exec - base, 32'd3);
            chk_val("loop_busy", {31'd0, busy}, 32'd0);
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        chk_val("final_sb", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
